// File: rtl/mc_ctrl_fsm_pkg.sv
// mc_ctrl_fsm_pkg: shared definitions for the multi-cycle MIPS main controller.
// Holds opcode/funct constants, the state encoding, the alu_op codes, the mux
// select codes and the packed control vector driven by mc_ctrl_outdec.
// Optional feature macro: MC_CTRL_JAL_EN adds the $31 / PC select codes.
package mc_ctrl_fsm_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] ALU_OR    = 2'd3;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
`ifdef MC_CTRL_JAL_EN
    localparam logic [1:0] REG_DST_RA = 2'd2;
    localparam logic [1:0] M2R_PC     = 2'd2;
`endif

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        I_EXEC   = 4'd8,
        I_WB     = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        JAL      = 4'd12,
        HALT     = 4'd13
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       ext_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic funct_legal(input logic [5:0] f);
        case (f)
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_SLT, FN_SLTU: funct_legal = 1'b1;
            default:                        funct_legal = 1'b0;
        endcase
    endfunction

    // States that wait on mem_ready and are covered by the timeout counter.
    function automatic logic is_mem_state(input state_e s);
        is_mem_state = (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: controller <-> datapath bundle.
// Datapath -> controller: op, funct, zero, mem_ready.
// Controller -> datapath: all strobes and mux selects.
// modport master = controller side, modport slave = datapath side.
interface mc_ctrl_fsm_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       ext_op;
    logic [1:0] pc_source;

    modport master (
        input  op, funct, zero, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               ext_op, pc_source
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               ext_op, pc_source
    );
endinterface

// File: rtl/mc_ctrl_fsm_outdec.sv
// mc_ctrl_outdec: combinational state/op -> control vector decoder.
// Ports: state_i (current state), op_i (IR opcode), mem_ready_i (gates the
// FETCH IR/PC loads), ctrl_o (full control vector).
// Optional feature macro: MC_CTRL_JAL_EN enables the JAL output row.
module mc_ctrl_outdec
    import mc_ctrl_fsm_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] op_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                // IR and PC only load on the cycle the fetch completes.
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH;
                ctrl_o.ext_op    = 1'b1;
            end
            MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.ext_op    = 1'b1;
            end
            MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REG_DST_RT;
                ctrl_o.mem_to_reg = M2R_MDR;
            end
            MEM_WR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            R_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RT;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            R_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REG_DST_RD;
                ctrl_o.mem_to_reg = M2R_ALUOUT;
            end
            I_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                if (op_i == OP_ORI) begin
                    ctrl_o.ext_op = 1'b0;
                    ctrl_o.alu_op = ALU_OR;
                end else begin
                    ctrl_o.ext_op = 1'b1;
                    ctrl_o.alu_op = ALU_ADD;
                end
            end
            I_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REG_DST_RT;
                ctrl_o.mem_to_reg = M2R_ALUOUT;
            end
            BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_RT;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
`ifdef MC_CTRL_JAL_EN
            JAL: begin
                // PC still holds PC+4 here, so the link value is correct.
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REG_DST_RA;
                ctrl_o.mem_to_reg = M2R_PC;
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle main controller for the single-memory MIPS datapath.
// Ports: clk, rst (sync, active-high); bus (mc_ctrl_fsm_if.master: op, funct,
// zero, mem_ready in; all strobes/selects out); state_o (debug state),
// halted (in HALT), mem_err (sticky memory timeout).
// Parameters: HALT_ON_ILLEGAL (1 = halt on unknown op, 0 = treat as NOP),
// MEM_TIMEOUT (max wait cycles in a memory state, 0 = no timeout).
// Optional feature macro: MC_CTRL_JAL_EN (jal support; otherwise jal is illegal).
//
// state    | meaning
// FETCH    | read instruction at PC, load IR and PC+4 on mem_ready
// DECODE   | branch target into ALUOut, dispatch on op
// MEM_ADDR | effective address rs + sext(imm)
// MEM_RD   | load data read, waits for mem_ready
// MEM_WB   | MDR -> rt
// MEM_WR   | store data write, waits for mem_ready
// R_EXEC   | rs funct rt
// R_WB     | ALUOut -> rd
// I_EXEC   | rs add/or ext(imm)
// I_WB     | ALUOut -> rt
// BRANCH   | compare rs/rt, PC <- ALUOut if zero
// JUMP     | PC <- jump target
// JAL      | $31 <- PC, PC <- jump target
// HALT     | illegal op or memory timeout, stays until rst
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int HALT_ON_ILLEGAL = 1,
    parameter int MEM_TIMEOUT     = 255
) (
    input  logic               clk,
    input  logic               rst,
    mc_ctrl_fsm_if.master      bus,
    output logic [3:0]         state_o,
    output logic               halted,
    output logic               mem_err
);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       mem_err_q, mem_err_d;
    state_e     illegal_next;
    logic       timeout;
    ctrl_t      dec;
    ctrl_t      ctrl;
    logic       unused_zero;

    // zero is consumed by the datapath together with pc_write_cond.
    assign unused_zero  = bus.zero;

    assign illegal_next = (HALT_ON_ILLEGAL != 0) ? HALT : FETCH;
    assign timeout      = (MEM_TIMEOUT != 0) && is_mem_state(state_q) &&
                          !bus.mem_ready && (wait_q == 8'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        mem_err_d = mem_err_q;
        unique case (state_q)
            FETCH:    if (bus.mem_ready) state_d = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW:    state_d = MEM_ADDR;
                    OP_RTYPE:        state_d = funct_legal(bus.funct) ? R_EXEC : illegal_next;
                    OP_ADDI, OP_ORI: state_d = I_EXEC;
                    OP_BEQ:          state_d = BRANCH;
                    OP_J:            state_d = JUMP;
`ifdef MC_CTRL_JAL_EN
                    OP_JAL:          state_d = JAL;
`endif
                    default:         state_d = illegal_next;
                endcase
            end
            MEM_ADDR: state_d = (bus.op == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:   if (bus.mem_ready) state_d = MEM_WB;
            MEM_WR:   if (bus.mem_ready) state_d = FETCH;
            R_EXEC:   state_d = R_WB;
            I_EXEC:   state_d = I_WB;
            HALT:     state_d = HALT;
            default:  state_d = FETCH;
        endcase
        if (timeout) begin
            state_d   = HALT;
            mem_err_d = 1'b1;
        end
        // Any state change clears the counter, so it restarts on memory-state entry.
        if (state_d != state_q)
            wait_d = '0;
        else if (is_mem_state(state_q) && !bus.mem_ready)
            wait_d = wait_q + 8'd1;
        else
            wait_d = wait_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
        end
    end

    mc_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .op_i        (bus.op),
        .mem_ready_i (bus.mem_ready),
        .ctrl_o      (dec)
    );

    // Reset must squash an in-flight access in the same cycle it is asserted.
    assign ctrl = rst ? ctrl_t'('0) : dec;

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.iord          = ctrl.iord;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.ext_op        = ctrl.ext_op;
    assign bus.pc_source     = ctrl.pc_source;

    assign state_o = state_q;
    assign halted  = (state_q == HALT) && !rst;
    assign mem_err = mem_err_q && !rst;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed self-checking bench for mc_ctrl_fsm.
// DUT built with HALT_ON_ILLEGAL = 1 and MEM_TIMEOUT = 4.
module tb_mc_ctrl_fsm;
    import mc_ctrl_fsm_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] state_o;
    logic       halted;
    logic       mem_err;
    int         total = 0;
    int         bad   = 0;

    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm #(
        .HALT_ON_ILLEGAL (1),
        .MEM_TIMEOUT     (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.master),
        .state_o (state_o),
        .halted  (halted),
        .mem_err (mem_err)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge, settle, then let the caller check.
    task automatic step(input logic r, input logic rdy, input logic [5:0] o, input logic [5:0] f);
        @(negedge clk);
        rst           = r;
        bus.mem_ready = rdy;
        bus.op        = o;
        bus.funct     = f;
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 6'b100011, 6'd0);
        step(1'b1, 1'b1, 6'b100011, 6'd0);
        total++; if (state_o !== 4'(FETCH)) begin bad++; $display("FAIL reset_state: got %0d want %0d", state_o, FETCH); end
        total++; if ({bus.mem_read, bus.ir_write, bus.pc_write, bus.alu_src_b} !== 5'd0) begin bad++;
            $display("FAIL reset_strobes: got %b want 00000", {bus.mem_read, bus.ir_write, bus.pc_write, bus.alu_src_b}); end
        total++; if ({mem_err, halted} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {mem_err, halted}); end
    endtask

    task automatic test_add();
        state_e exp [6] = '{FETCH, DECODE, R_EXEC, R_WB, FETCH, DECODE};
        logic   rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        step(1'b1, 1'b0, 6'b000000, 6'b100000);
        for (int c = 0; c < 6; c++) begin
            step(1'b0, rdy[c], 6'b000000, 6'b100000);
            total++; if (state_o !== 4'(exp[c])) begin bad++; $display("FAIL add_state c%0d: got %0d want %0d", c, state_o, exp[c]); end
            if (c == 0) begin
                total++; if ({bus.ir_write, bus.pc_write, bus.mem_read, bus.alu_src_b} !== 5'b11101) begin bad++;
                    $display("FAIL add_fetch: got %b want 11101", {bus.ir_write, bus.pc_write, bus.mem_read, bus.alu_src_b}); end
            end
            if (c == 1) begin
                total++; if ({bus.alu_src_b, bus.ext_op, bus.alu_op} !== 5'b11100) begin bad++;
                    $display("FAIL add_decode: got %b want 11100", {bus.alu_src_b, bus.ext_op, bus.alu_op}); end
            end
            if (c == 2) begin
                total++; if ({bus.alu_src_a, bus.alu_src_b, bus.alu_op} !== 5'b10010) begin bad++;
                    $display("FAIL add_exec: got %b want 10010", {bus.alu_src_a, bus.alu_src_b, bus.alu_op}); end
            end
            if (c == 3) begin
                total++; if ({bus.reg_write, bus.reg_dst, bus.mem_to_reg} !== 5'b10100) begin bad++;
                    $display("FAIL add_wb: got %b want 10100", {bus.reg_write, bus.reg_dst, bus.mem_to_reg}); end
            end
        end
    endtask

    task automatic test_lw_wait();
        state_e exp [8] = '{FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_RD, MEM_RD, MEM_WB, FETCH};
        logic   rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int wb_cnt = 0;
        int ir_bad = 0;
        int both   = 0;
        step(1'b1, 1'b0, 6'b100011, 6'd0);
        for (int c = 0; c < 8; c++) begin
            step(1'b0, rdy[c], 6'b100011, 6'd0);
            total++; if (state_o !== 4'(exp[c])) begin bad++; $display("FAIL lw_state c%0d: got %0d want %0d", c, state_o, exp[c]); end
            if (c < 7 && bus.reg_write && bus.mem_to_reg == 2'd1) wb_cnt++;
            if (state_o != 4'(FETCH) && bus.ir_write) ir_bad++;
            if (bus.mem_read && bus.mem_write) both++;
            if (c == 3) begin
                total++; if ({bus.mem_read, bus.iord, bus.mem_write} !== 3'b110) begin bad++;
                    $display("FAIL lw_memrd: got %b want 110", {bus.mem_read, bus.iord, bus.mem_write}); end
            end
            if (c == 2) begin
                total++; if ({bus.alu_src_a, bus.alu_src_b, bus.ext_op} !== 4'b1101) begin bad++;
                    $display("FAIL lw_addr: got %b want 1101", {bus.alu_src_a, bus.alu_src_b, bus.ext_op}); end
            end
        end
        total++; if (wb_cnt !== 1) begin bad++; $display("FAIL lw_wb_count: got %0d want 1", wb_cnt); end
        total++; if (ir_bad !== 0) begin bad++; $display("FAIL lw_ir_outside_fetch: got %0d want 0", ir_bad); end
        total++; if (both !== 0) begin bad++; $display("FAIL lw_rd_wr_overlap: got %0d want 0", both); end
    endtask

    task automatic test_beq(input logic z);
        bus.zero = z;
        step(1'b1, 1'b0, 6'b000100, 6'd0);
        step(1'b0, 1'b1, 6'b000100, 6'd0);
        step(1'b0, 1'b1, 6'b000100, 6'd0);
        step(1'b0, 1'b1, 6'b000100, 6'd0);
        total++; if (state_o !== 4'(BRANCH)) begin bad++; $display("FAIL beq_state z%0d: got %0d want %0d", z, state_o, BRANCH); end
        total++; if ({bus.pc_write_cond, bus.pc_source, bus.reg_write, bus.alu_op, bus.pc_write} !== 7'b1010010) begin bad++;
            $display("FAIL beq_ctrl z%0d: got %b want 1010010", z, {bus.pc_write_cond, bus.pc_source, bus.reg_write, bus.alu_op, bus.pc_write}); end
        step(1'b0, 1'b0, 6'b000100, 6'd0);
        total++; if (state_o !== 4'(FETCH)) begin bad++; $display("FAIL beq_next z%0d: got %0d want %0d", z, state_o, FETCH); end
        bus.zero = 1'b0;
    endtask

    task automatic test_imm(input logic [5:0] o, input logic ext, input logic [1:0] aop);
        step(1'b1, 1'b0, o, 6'd0);
        step(1'b0, 1'b1, o, 6'd0);
        step(1'b0, 1'b1, o, 6'd0);
        step(1'b0, 1'b1, o, 6'd0);
        total++; if ({state_o, bus.alu_src_a, bus.alu_src_b, bus.ext_op, bus.alu_op} !== {4'(I_EXEC), 1'b1, 2'd2, ext, aop}) begin bad++;
            $display("FAIL imm_exec op%b: got %b want %b", o, {state_o, bus.alu_src_a, bus.alu_src_b, bus.ext_op, bus.alu_op}, {4'(I_EXEC), 1'b1, 2'd2, ext, aop}); end
        step(1'b0, 1'b1, o, 6'd0);
        total++; if ({state_o, bus.reg_write, bus.reg_dst, bus.mem_to_reg} !== {4'(I_WB), 5'b10000}) begin bad++;
            $display("FAIL imm_wb op%b: got %b want %b", o, {state_o, bus.reg_write, bus.reg_dst, bus.mem_to_reg}, {4'(I_WB), 5'b10000}); end
    endtask

    task automatic test_jump();
        step(1'b1, 1'b0, 6'b000010, 6'd0);
        step(1'b0, 1'b1, 6'b000010, 6'd0);
        step(1'b0, 1'b1, 6'b000010, 6'd0);
        step(1'b0, 1'b0, 6'b000010, 6'd0);
        total++; if ({state_o, bus.pc_write, bus.pc_source, bus.reg_write} !== {4'(JUMP), 4'b1100}) begin bad++;
            $display("FAIL jump: got %b want %b", {state_o, bus.pc_write, bus.pc_source, bus.reg_write}, {4'(JUMP), 4'b1100}); end
    endtask

    task automatic test_jal();
        step(1'b1, 1'b0, 6'b000011, 6'd0);
        step(1'b0, 1'b1, 6'b000011, 6'd0);
        step(1'b0, 1'b1, 6'b000011, 6'd0);
        step(1'b0, 1'b0, 6'b000011, 6'd0);
`ifdef MC_CTRL_JAL_EN
        total++; if ({state_o, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.pc_write, bus.pc_source} !== {4'(JAL), 8'b11010110}) begin bad++;
            $display("FAIL jal: got %b want %b", {state_o, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.pc_write, bus.pc_source}, {4'(JAL), 8'b11010110}); end
`else
        total++; if ({state_o, halted, bus.reg_write, bus.pc_write} !== {4'(HALT), 3'b100}) begin bad++;
            $display("FAIL jal_illegal: got %b want %b", {state_o, halted, bus.reg_write, bus.pc_write}, {4'(HALT), 3'b100}); end
`endif
    endtask

    task automatic test_illegal();
        step(1'b1, 1'b0, 6'b111111, 6'd0);
        step(1'b0, 1'b1, 6'b111111, 6'd0);
        step(1'b0, 1'b1, 6'b111111, 6'd0);
        total++; if (state_o !== 4'(DECODE)) begin bad++; $display("FAIL ill_decode: got %0d want %0d", state_o, DECODE); end
        step(1'b0, 1'b1, 6'b111111, 6'd0);
        total++; if ({state_o, halted, bus.mem_read, bus.ir_write} !== {4'(HALT), 3'b100}) begin bad++;
            $display("FAIL ill_halt: got %b want %b", {state_o, halted, bus.mem_read, bus.ir_write}, {4'(HALT), 3'b100}); end
        step(1'b0, 1'b1, 6'b000000, 6'b100000);
        total++; if ({state_o, halted} !== {4'(HALT), 1'b1}) begin bad++;
            $display("FAIL ill_stay: got %b want %b", {state_o, halted}, {4'(HALT), 1'b1}); end
        step(1'b1, 1'b0, 6'd0, 6'd0);
        step(1'b0, 1'b0, 6'd0, 6'd0);
        total++; if ({state_o, halted} !== {4'(FETCH), 1'b0}) begin bad++;
            $display("FAIL ill_reset: got %b want %b", {state_o, halted}, {4'(FETCH), 1'b0}); end
        // R-type with an unlisted funct is also illegal.
        step(1'b0, 1'b1, 6'b000000, 6'b111111);
        step(1'b0, 1'b1, 6'b000000, 6'b111111);
        step(1'b0, 1'b1, 6'b000000, 6'b111111);
        total++; if ({state_o, halted} !== {4'(HALT), 1'b1}) begin bad++;
            $display("FAIL ill_funct: got %b want %b", {state_o, halted}, {4'(HALT), 1'b1}); end
    endtask

    task automatic test_fetch_wait();
        step(1'b1, 1'b0, 6'b000010, 6'd0);
        step(1'b0, 1'b0, 6'b000010, 6'd0);
        step(1'b0, 1'b0, 6'b000010, 6'd0);
        total++; if ({state_o, bus.mem_read, bus.ir_write, bus.pc_write} !== {4'(FETCH), 3'b100}) begin bad++;
            $display("FAIL fetch_wait: got %b want %b", {state_o, bus.mem_read, bus.ir_write, bus.pc_write}, {4'(FETCH), 3'b100}); end
        step(1'b0, 1'b1, 6'b000010, 6'd0);
        step(1'b0, 1'b0, 6'b000010, 6'd0);
        total++; if (state_o !== 4'(DECODE)) begin bad++; $display("FAIL fetch_release: got %0d want %0d", state_o, DECODE); end
    endtask

    task automatic test_timeout();
        step(1'b1, 1'b0, 6'b101011, 6'd0);
        step(1'b0, 1'b1, 6'b101011, 6'd0);
        step(1'b0, 1'b1, 6'b101011, 6'd0);
        step(1'b0, 1'b1, 6'b101011, 6'd0);
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 1'b0, 6'b101011, 6'd0);
            total++; if ({state_o, bus.mem_write, bus.iord, bus.mem_read, mem_err} !== {4'(MEM_WR), 4'b1100}) begin bad++;
                $display("FAIL to_wait w%0d: got %b want %b", c, {state_o, bus.mem_write, bus.iord, bus.mem_read, mem_err}, {4'(MEM_WR), 4'b1100}); end
        end
        step(1'b0, 1'b1, 6'b101011, 6'd0);
        total++; if ({state_o, mem_err, halted, bus.mem_write} !== {4'(HALT), 3'b110}) begin bad++;
            $display("FAIL to_halt: got %b want %b", {state_o, mem_err, halted, bus.mem_write}, {4'(HALT), 3'b110}); end
        step(1'b0, 1'b1, 6'b101011, 6'd0);
        total++; if (mem_err !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", mem_err); end
        step(1'b1, 1'b0, 6'd0, 6'd0);
        step(1'b0, 1'b0, 6'd0, 6'd0);
        total++; if ({state_o, mem_err} !== {4'(FETCH), 1'b0}) begin bad++;
            $display("FAIL to_clear: got %b want %b", {state_o, mem_err}, {4'(FETCH), 1'b0}); end
    endtask

    task automatic test_reset_mid_wr();
        step(1'b1, 1'b0, 6'b101011, 6'd0);
        step(1'b0, 1'b1, 6'b101011, 6'd0);
        step(1'b0, 1'b1, 6'b101011, 6'd0);
        step(1'b0, 1'b1, 6'b101011, 6'd0);
        step(1'b0, 1'b0, 6'b101011, 6'd0);
        total++; if ({state_o, bus.mem_write} !== {4'(MEM_WR), 1'b1}) begin bad++;
            $display("FAIL rstwr_pre: got %b want %b", {state_o, bus.mem_write}, {4'(MEM_WR), 1'b1}); end
        step(1'b1, 1'b0, 6'b101011, 6'd0);
        total++; if ({bus.mem_write, bus.iord} !== 2'b00) begin bad++;
            $display("FAIL rstwr_same_cycle: got %b want 00", {bus.mem_write, bus.iord}); end
        step(1'b0, 1'b0, 6'b101011, 6'd0);
        total++; if ({state_o, bus.mem_write} !== {4'(FETCH), 1'b0}) begin bad++;
            $display("FAIL rstwr_after: got %b want %b", {state_o, bus.mem_write}, {4'(FETCH), 1'b0}); end
    endtask

    initial begin
        bus.mem_ready = 1'b0;
        bus.op        = 6'd0;
        bus.funct     = 6'd0;
        bus.zero      = 1'b0;
        test_reset();
        test_add();
        test_lw_wait();
        test_beq(1'b1);
        test_beq(1'b0);
        test_imm(6'b001000, 1'b1, 2'b00);
        test_imm(6'b001101, 1'b0, 2'b11);
        test_jump();
        test_jal();
        test_illegal();
        test_fetch_wait();
        test_timeout();
        test_reset_mid_wr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
